instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage for the 64-bit RISC-V datapath. It holds the program counter and a word-organised instruction memory with a load port. Each cycle it delivers one 32-bit instruction, with its PC and a valid flag, through a registered IF/ID boundary to the decode/register-file stage that consumes `instruction`. It supports stall, branch redirect with flush, and a sticky misaligned-target halt.

## Interface
Parameters:
- `ADDR_W`, 8: instruction memory word-address width; memory holds 2^ADDR_W 32-bit words.
- `RESET_PC`, 64'h0: PC value loaded on reset; must be 4-byte aligned.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID outputs this cycle.
- `branch_taken`  in  1  redirect PC to `branch_target`; has priority over `stall`.
- `branch_target`  in  64  redirect byte address.
- `load_en`  in  1  write `load_data` into instruction memory.
- `load_addr`  in  ADDR_W  word index for load.
- `load_data`  in  32  instruction word to store.
- `instruction`  out  32  registered instruction to decode.
- `pc_out`  out  64  byte address of `instruction`.
- `valid`  out  1  `instruction` is a real fetched instruction (not bubble).
- `misaligned`  out  1  sticky: a branch target with nonzero [1:0] was seen; fetch halted.
- `fetch_count`  out  32  number of valid instructions delivered since reset.

## Operation
- State machine: RUN, HALT.
- Reset (any state, has highest priority): pc=RESET_PC, `instruction`=32'h00000013 (NOP), `pc_out`=0, `valid`=0, `misaligned`=0, `fetch_count`=0, state=RUN. Memory contents are not cleared.
- The memory word index is pc[ADDR_W+1:2]. Upper PC bits are ignored, so addresses wrap modulo 2^ADDR_W words. The PC itself is 64-bit and wraps at 2^64.
- RUN, priority order:
  - `branch_taken` with branch_target[1:0]==0: pc<=branch_target, `instruction`<=NOP, `valid`<=0 (flush). `pc_out` holds.
  - `branch_taken` with branch_target[1:0]!=0: `misaligned`<=1, state<=HALT, `valid`<=0, `instruction`<=NOP. pc unchanged.
  - `stall` (no branch): pc, `instruction`, `pc_out`, `valid`, and `fetch_count` all hold.
  - Otherwise: `instruction`<=mem[pc index], `pc_out`<=pc, `valid`<=1, pc<=pc+4, `fetch_count`<=`fetch_count`+1 (wraps at 2^32).
- HALT:
  - `valid`=0, `instruction`=NOP, `misaligned`=1.
  - pc and `fetch_count` are frozen.
  - `branch_taken` and `stall` are ignored.
  - Only reset exits HALT.
- Load port:
  - When `load_en`=1, mem[load_addr]<=load_data at the edge.
  - Honoured in every state, including during reset.
  - The read is read-before-write: a fetch of the same word in the same cycle returns the old contents.

## Timing
- Fetch latency: one cycle. PC presented at edge N appears on `pc_out`/`instruction` after edge N.
- First valid instruction: the first edge with reset=0 and stall=0 produces `valid`=1, `pc_out`=RESET_PC.
- Branch penalty: exactly one bubble cycle (`valid`=0). The target instruction appears on the second edge after `branch_taken`, provided no stall is asserted.
- `branch_taken` and `stall` together: the branch wins, and the stall is dropped for that cycle.
- Stall after a branch: the bubble persists (`valid` stays 0) for as long as stall is held.
- Reset asserted mid-stream (including while HALT or stalled): outputs take reset values after that edge. No partial update occurs.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Hold reset and load mem[0..3]=0x00A00093, 0x01400113, 0x002081B3, 0x00000013; release reset. Required: next edges give (pc_out 0, 0x00A00093, valid 1), then (4, 0x01400113), then (8, 0x002081B3); `fetch_count`=3.
- From the previous scenario, assert stall for 2 cycles after pc_out=4. Required: outputs and `fetch_count` unchanged for both cycles. On release, pc_out=8 follows.
- Assert `branch_taken` with target 0x4 together with stall. Required: next cycle valid=0, instruction=0x00000013. The following cycle gives pc_out=4, instruction=0x01400113, valid=1.
- Branch to 0x6. Required: misaligned=1 and valid=0 from the next cycle. A later branch to 0x0 and stall toggling have no effect. Reset clears misaligned and restarts at pc_out=0.
- With ADDR_W=8, load mem[255]=0xDEADBEEF and branch to 0x3FC. Required: (0x3FC, 0xDEADBEEF), then (0x400, mem[0] contents).
- While fetching pc 0x8, assert load_en to word 2 with 0x12345678 in the same cycle. Required: the old word is delivered. A later branch back to 0x8 delivers 0x12345678.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, word-organised instruction memory,
// registered IF/ID outputs with stall, branch flush and misaligned halt.
module instruction_fetch #(
  parameter int          ADDR_W   = 8,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [63:0]       branch_target,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [31:0]       instruction,
  output logic [63:0]       pc_out,
  output logic              valid,
  output logic              misaligned,
  output logic [31:0]       fetch_count
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_d;
  logic [63:0] pcout_d;
  logic        valid_d;
  logic        mis_d;
  logic [31:0] cnt_d;

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata;

  logic br_ok, br_bad, hold, go;

  assign rdata  = mem[pc_q[ADDR_W+1:2]];
  assign br_ok  = branch_taken && (branch_target[1:0] == 2'b00);
  assign br_bad = branch_taken && (branch_target[1:0] != 2'b00);
  assign hold   = !branch_taken && stall;
  assign go     = !branch_taken && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instruction;
    pcout_d = pc_out;
    valid_d = valid;
    mis_d   = misaligned;
    cnt_d   = fetch_count;
    unique case (state_q)
      RUN: begin
        unique case (1'b1)
          br_ok: begin
            pc_d    = branch_target;
            instr_d = NOP;
            valid_d = 1'b0;
          end
          br_bad: begin
            mis_d   = 1'b1;
            state_d = HALT;
            instr_d = NOP;
            valid_d = 1'b0;
          end
          hold: begin
          end
          go: begin
            instr_d = rdata;
            pcout_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 64'd4;
            cnt_d   = fetch_count + 32'd1;
          end
          default: begin
          end
        endcase
      end
      HALT: begin
        instr_d = NOP;
        valid_d = 1'b0;
        mis_d   = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      instruction <= NOP;
      pc_out      <= 64'h0;
      valid       <= 1'b0;
      misaligned  <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instruction <= instr_d;
      pc_out      <= pcout_d;
      valid       <= valid_d;
      misaligned  <= mis_d;
      fetch_count <= cnt_d;
    end
  end

  // Load port is independent of reset and fetch state
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed vectors push
// expected IF/ID outputs, a monitor pops and compares each cycle.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'h0;
  logic [31:0] load_data = 32'h0;
  logic [31:0] instruction;
  logic [63:0] pc_out;
  logic        valid;
  logic        misaligned;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        v;
    logic        m;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(8), .RESET_PC(64'h0)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .instruction(instruction),
    .pc_out(pc_out),
    .valid(valid),
    .misaligned(misaligned),
    .fetch_count(fetch_count)
  );

  task automatic step(
    input logic        rst,
    input logic        st,
    input logic        br,
    input logic [63:0] tgt,
    input logic        ld,
    input logic [7:0]  la,
    input logic [31:0] ldat,
    input logic [31:0] ei,
    input logic [63:0] ep,
    input logic        ev,
    input logic        em,
    input logic [31:0] ec
  );
    exp_t e;
    @(negedge clk);
    reset         = rst;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    load_en       = ld;
    load_addr     = la;
    load_data     = ldat;
    e.instr = ei;
    e.pc    = ep;
    e.v     = ev;
    e.m     = em;
    e.cnt   = ec;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (instruction !== e.instr || pc_out !== e.pc ||
            valid !== e.v || misaligned !== e.m ||
            fetch_count !== e.cnt) begin
          miscompares++;
          $display("FAIL vec%0d: got instr=%h pc=%h v=%b m=%b cnt=%0d, want instr=%h pc=%h v=%b m=%b cnt=%0d",
                   vectors, instruction, pc_out, valid, misaligned,
                   fetch_count, e.instr, e.pc, e.v, e.m, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    int waited;
    // reset held while loading program (and the top word)
    step(1,0,0,64'h0, 1,8'd0,  32'h00A00093, NOP,64'h0,0,0,0);
    step(1,0,0,64'h0, 1,8'd1,  32'h01400113, NOP,64'h0,0,0,0);
    step(1,0,0,64'h0, 1,8'd2,  32'h002081B3, NOP,64'h0,0,0,0);
    step(1,0,0,64'h0, 1,8'd3,  32'h00000013, NOP,64'h0,0,0,0);
    step(1,0,0,64'h0, 1,8'd255,32'hDEADBEEF, NOP,64'h0,0,0,0);
    // first fetches
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'h00A00093,64'h0,1,0,1);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'h01400113,64'h4,1,0,2);
    // stall two cycles
    step(0,1,0,64'h0, 0,8'd0,32'h0, 32'h01400113,64'h4,1,0,2);
    step(0,1,0,64'h0, 0,8'd0,32'h0, 32'h01400113,64'h4,1,0,2);
    // fetch pc 8 while overwriting word 2: old word delivered
    step(0,0,0,64'h0, 1,8'd2,32'h12345678, 32'h002081B3,64'h8,1,0,3);
    // branch to 4 with stall: branch wins, bubble
    step(0,1,1,64'h4, 0,8'd0,32'h0, NOP,64'h8,0,0,3);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'h01400113,64'h4,1,0,4);
    // branch back to 8, bubble held by stall
    step(0,0,1,64'h8, 0,8'd0,32'h0, NOP,64'h4,0,0,4);
    step(0,1,0,64'h0, 0,8'd0,32'h0, NOP,64'h4,0,0,4);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'h12345678,64'h8,1,0,5);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'h00000013,64'hC,1,0,6);
    // top of memory and word-index wrap
    step(0,0,1,64'h3FC, 0,8'd0,32'h0, NOP,64'hC,0,0,6);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'hDEADBEEF,64'h3FC,1,0,7);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'h00A00093,64'h400,1,0,8);
    // 64-bit PC wrap
    step(0,0,1,64'hFFFF_FFFF_FFFF_FFFC, 0,8'd0,32'h0, NOP,64'h400,0,0,8);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'hDEADBEEF,64'hFFFF_FFFF_FFFF_FFFC,1,0,9);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'h00A00093,64'h0,1,0,10);
    // misaligned branch halts; everything else ignored
    step(0,0,1,64'h6, 0,8'd0,32'h0, NOP,64'h0,0,1,10);
    step(0,1,1,64'h0, 0,8'd0,32'h0, NOP,64'h0,0,1,10);
    step(0,1,0,64'h0, 0,8'd0,32'h0, NOP,64'h0,0,1,10);
    step(0,0,0,64'h0, 0,8'd0,32'h0, NOP,64'h0,0,1,10);
    // reset exits halt and restarts at 0
    step(1,0,0,64'h0, 0,8'd0,32'h0, NOP,64'h0,0,0,0);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'h00A00093,64'h0,1,0,1);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'h01400113,64'h4,1,0,2);
    // reset while stalled
    step(1,1,0,64'h0, 0,8'd0,32'h0, NOP,64'h0,0,0,0);
    step(0,0,0,64'h0, 0,8'd0,32'h0, 32'h00A00093,64'h0,1,0,1);
    @(negedge clk);
    stall = 1'b1;
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
